// File: rtl/hazard_issue_scheduler_if.sv
// Handshake bundle between decode, the hazard issue scheduler and execute.
// ISSUE_REORDER_STATS_EN adds the reorder/issue statistics counters.
interface hazard_issue_scheduler_if #(
    parameter int IW = 32,
    parameter int BS = 16
) ();
    localparam int IDXW = $clog2(BS);
    localparam int CW   = IDXW + 1;

    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_instr;
    logic            in_regwrite;
    logic            in_alusrc;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_instr;
    logic [IDXW-1:0] out_index;
    logic [CW-1:0]   count;
    logic            draining;
`ifdef ISSUE_REORDER_STATS_EN
    logic [31:0]     reorder_cnt;
    logic [31:0]     issue_cnt;
`endif

    modport slave (
        input  in_valid, in_instr, in_regwrite, in_alusrc, out_ready,
        output in_ready, out_valid, out_instr, out_index, count, draining
`ifdef ISSUE_REORDER_STATS_EN
        , output reorder_cnt, issue_cnt
`endif
    );

    modport master (
        output in_valid, in_instr, in_regwrite, in_alusrc, out_ready,
        input  in_ready, out_valid, out_instr, out_index, count, draining
`ifdef ISSUE_REORDER_STATS_EN
        , input reorder_cnt, issue_cnt
`endif
    );
endinterface

// File: rtl/hazard_issue_scheduler.sv
// Fills a BS-entry window in program order, then issues the oldest hazard-free entry each cycle.
// Optional macro ISSUE_REORDER_STATS_EN adds saturating reorder_cnt / issue_cnt outputs.
module hazard_issue_scheduler #(
    parameter int IW     = 32,
    parameter int BS     = 16,
    parameter int REGNUM = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_issue_scheduler_if.slave bus
);
    localparam int IDXW = $clog2(BS);
    localparam int CW   = IDXW + 1;
    localparam int RW   = $clog2(REGNUM);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BS-1:0]     valid_q, valid_d;

    logic [IW-1:0]     instr_q [BS];
    logic [RW-1:0]     rd_q    [BS];
    logic [RW-1:0]     rs1_q   [BS];
    logic [RW-1:0]     rs2_q   [BS];
    logic [BS-1:0]     wr_q;
    logic [BS-1:0]     use2_q;

    logic              store_en;
    logic              flush;
    logic              issue_en;
    logic [BS-1:0]     blocked;
    logic [BS-1:0]     eligible;
    logic              sel_found;
    logic [IDXW-1:0]   sel_idx;
    logic [IDXW-1:0]   oldest_idx;

    // Older entry i against younger entry j; x0 never forms a hazard.
    function automatic logic hazard(
        input logic          wr_i,
        input logic [RW-1:0] rd_i,
        input logic [RW-1:0] rs1_i,
        input logic [RW-1:0] rs2_i,
        input logic          use2_i,
        input logic          wr_j,
        input logic [RW-1:0] rd_j,
        input logic [RW-1:0] rs1_j,
        input logic [RW-1:0] rs2_j,
        input logic          use2_j
    );
        logic raw, waw, war;
        raw = wr_i && (rd_i != '0) && ((rd_i == rs1_j) || (use2_j && (rd_i == rs2_j)));
        waw = wr_i && wr_j && (rd_i == rd_j) && (rd_i != '0);
        war = wr_j && (rd_j != '0) && ((rd_j == rs1_i) || (use2_i && (rd_j == rs2_i)));
        return raw || waw || war;
    endfunction

    always_comb begin
        blocked = '0;
        for (int j = 0; j < BS; j++) begin
            for (int i = 0; i < j; i++) begin
                if (valid_q[i] && hazard(wr_q[i], rd_q[i], rs1_q[i], rs2_q[i], use2_q[i],
                                         wr_q[j], rd_q[j], rs1_q[j], rs2_q[j], use2_q[j]))
                    blocked[j] = 1'b1;
            end
        end
        eligible = valid_q & ~blocked;
    end

    // Downward scans leave the lowest matching index in the result.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        oldest_idx = '0;
        for (int k = BS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(k);
            end
            if (valid_q[k])
                oldest_idx = IDXW'(k);
        end
    end

    assign store_en = (state_q == S_FILL) && bus.in_valid && (bus.in_instr != '0);
    assign flush    = (state_q == S_FILL) && bus.in_valid && (bus.in_instr == '0);
    assign issue_en = (state_q == S_DRAIN) && sel_found && bus.out_ready;

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.draining  = (state_q == S_DRAIN);
    assign bus.out_valid = (state_q == S_DRAIN) && sel_found;
    assign bus.out_instr = bus.out_valid ? instr_q[sel_idx] : '0;
    assign bus.out_index = bus.out_valid ? sel_idx : '0;
    assign bus.count     = count_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        case (state_q)
            S_FILL: begin
                if (store_en) begin
                    valid_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d          = wr_ptr_q + 1'b1;
                    count_d           = count_q + 1'b1;
                    if (count_q == CW'(BS - 1))
                        state_d = S_DRAIN;
                end else if (flush && (count_q != '0)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (issue_en) begin
                    valid_d[sel_idx] = 1'b0;
                    count_d          = count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d  = S_FILL;
                        wr_ptr_d = '0;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            instr_q[wr_ptr_q] <= bus.in_instr;
            rd_q[wr_ptr_q]    <= bus.in_instr[7 +: RW];
            rs1_q[wr_ptr_q]   <= bus.in_instr[15 +: RW];
            rs2_q[wr_ptr_q]   <= bus.in_instr[20 +: RW];
            wr_q[wr_ptr_q]    <= bus.in_regwrite;
            use2_q[wr_ptr_q]  <= ~bus.in_alusrc;
        end
    end

`ifdef ISSUE_REORDER_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] reorder_cnt_q, reorder_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        reorder_cnt_d = reorder_cnt_q;
        if (issue_en) begin
            issue_cnt_d = sat_inc(issue_cnt_q);
            if (sel_idx != oldest_idx)
                reorder_cnt_d = sat_inc(reorder_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q   <= '0;
            reorder_cnt_q <= '0;
        end else begin
            issue_cnt_q   <= issue_cnt_d;
            reorder_cnt_q <= reorder_cnt_d;
        end
    end

    assign bus.issue_cnt   = issue_cnt_q;
    assign bus.reorder_cnt = reorder_cnt_q;
`else
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;
`endif

endmodule

// File: tb/tb_hazard_issue_scheduler.sv
// Directed bench for hazard_issue_scheduler with a 4-entry window.
module tb_hazard_issue_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_issue_scheduler_if #(.IW(32), .BS(4)) bus ();

    hazard_issue_scheduler #(.IW(32), .BS(4), .REGNUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] mk_i(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] ins, input logic rw, input logic as);
        check("push_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid    = 1'b1;
        bus.in_instr    = ins;
        bus.in_regwrite = rw;
        bus.in_alusrc   = as;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
    endtask

    task automatic expect_issue(input int idx, input logic [31:0] ins, input int cnt);
        bus.out_ready = 1'b1;
        check("iss_valid", 64'(bus.out_valid), 64'd1);
        check("iss_index", 64'(bus.out_index), 64'(idx));
        check("iss_instr", 64'(bus.out_instr), 64'(ins));
        check("iss_count", 64'(bus.count), 64'(cnt));
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"}, 64'(bus.count), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_draining"}, 64'(bus.draining), 64'd0);
    endtask

    logic [31:0] a0, a1, a2, a3;

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_regwrite = 1'b0;
        bus.in_alusrc   = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) tick();
        check_idle("reset");
        check("reset_out_instr", 64'(bus.out_instr), 64'd0);
        check("reset_out_index", 64'(bus.out_index), 64'd0);
        rst = 1'b0;
        tick();

        // Four independent adds; the window fills and drains in order.
        a0 = mk_r(1, 2, 3);  a1 = mk_r(4, 5, 6);
        a2 = mk_r(7, 8, 9);  a3 = mk_r(10, 11, 12);
        bus.out_ready = 1'b1;
        push(a0, 1, 0);
        check("fill_out_valid", 64'(bus.out_valid), 64'd0);
        push(a1, 1, 0); push(a2, 1, 0); push(a3, 1, 0);
        check("full_draining", 64'(bus.draining), 64'd1);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1; bus.in_instr = mk_r(20, 21, 22);
        expect_issue(0, a0, 4);
        expect_issue(1, a1, 3);
        expect_issue(2, a2, 2);
        expect_issue(3, a3, 1);
        bus.in_valid = 1'b0; bus.in_instr = '0;
        check_idle("t1_done");

        // RAW on slot 0, closed by a flush marker.
        a0 = mk_r(1, 2, 3); a1 = mk_r(4, 1, 5); a2 = mk_r(6, 7, 8);
        push(a0, 1, 0); push(a1, 1, 0); push(a2, 1, 0);
        push(32'h0, 0, 0);
        check("t2_draining", 64'(bus.draining), 64'd1);
        check("t2_count", 64'(bus.count), 64'd3);
        expect_issue(0, a0, 3);
        expect_issue(1, a1, 2);
        expect_issue(2, a2, 1);
        check_idle("t2_done");

        // Same window with execute stalled for three cycles.
        bus.out_ready = 1'b0;
        push(a0, 1, 0); push(a1, 1, 0); push(a2, 1, 0);
        push(32'h0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_index", 64'(bus.out_index), 64'd0);
            check("stall_instr", 64'(bus.out_instr), 64'(a0));
            check("stall_count", 64'(bus.count), 64'd3);
            tick();
        end
        expect_issue(0, a0, 3);
        expect_issue(1, a1, 2);
        expect_issue(2, a2, 1);
        check_idle("t3_done");

        // Dependent chain with WAW on slot 1; addi rs2 field aliases x1 but is unused.
        a0 = mk_r(1, 2, 3); a1 = mk_r(9, 1, 1);
        a2 = mk_i(10, 11, 1); a3 = mk_r(9, 12, 13);
        bus.out_ready = 1'b0;
        push(a0, 1, 0); push(a1, 1, 0); push(a2, 1, 1); push(a3, 1, 0);
        for (int c = 0; c < 2; c++) begin
            check("hold_index", 64'(bus.out_index), 64'd0);
            check("hold_instr", 64'(bus.out_instr), 64'(a0));
            tick();
        end
        expect_issue(0, a0, 4);
        expect_issue(1, a1, 3);
        expect_issue(2, a2, 2);
        expect_issue(3, a3, 1);
        check_idle("t4_done");

`ifdef ISSUE_REORDER_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("stat_reset_issue", 64'(bus.issue_cnt), 64'd0);
        a0 = mk_r(1, 2, 3); a1 = mk_r(5, 1, 4); a2 = mk_r(6, 7, 8);
        push(a0, 1, 0); push(a1, 1, 0); push(a2, 1, 0);
        push(32'h0, 0, 0);
        expect_issue(0, a0, 3);
        expect_issue(1, a1, 2);
        expect_issue(2, a2, 1);
        check("stat_issue_cnt", 64'(bus.issue_cnt), 64'd3);
        check("stat_reorder_cnt", 64'(bus.reorder_cnt), 64'd0);
`endif

        // Flush with an empty window is a no-op.
        bus.out_ready = 1'b1;
        push(32'h0, 0, 0);
        check_idle("empty_flush");

        // Two accepted, then flush.
        a0 = mk_r(3, 4, 5); a1 = mk_i(6, 3, 7);
        push(a0, 1, 0); push(a1, 1, 1);
        push(32'h0, 0, 0);
        check("flush2_draining", 64'(bus.draining), 64'd1);
        check("flush2_count", 64'(bus.count), 64'd2);
        expect_issue(0, a0, 2);
        expect_issue(1, a1, 1);
        check_idle("flush2_done");

        // Asynchronous reset in the middle of a drain of three.
        bus.out_ready = 1'b0;
        push(mk_r(1, 2, 3), 1, 0); push(mk_r(4, 5, 6), 1, 0); push(mk_r(7, 8, 9), 1, 0);
        push(32'h0, 0, 0);
        check("pre_rst_draining", 64'(bus.draining), 64'd1);
        check("pre_rst_count", 64'(bus.count), 64'd3);
        #2 rst = 1'b1;
        #1 check("async_rst_count", 64'(bus.count), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check_idle("post_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_no_issue", 64'(bus.out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
